m_bpred_btb: RTL and testbench

- Parametrised branch target buffer and direction predictor for the m_proc pipeline family.
- Fully associative, ENTRIES ways with true-LRU replacement and valid bits; each way holds a CTR_W-bit saturating counter and a branch target.
- Lookup is combinational from the IF-stage PC. Update is registered from the EX-stage branch resolution.
- New in this generation:
  - flush port;
  - allocate-on-taken-only mode;
  - target refresh on hit;
  - mispredict/update performance counters.

---
 rtl/m_bpred_pkg.sv | 42 ++++
 rtl/m_bpred_cam.sv | 28 ++
 rtl/m_bpred_btb.sv | 144 ++++++++++++++
 tb/tb_m_bpred_btb.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/m_bpred_pkg.sv
// rtl/m_bpred_pkg.sv - shared constants and helper functions for the m_bpred BTB
package m_bpred_pkg;

  // Weakly-taken counter value: the smallest value whose MSB is set.
  function automatic int f_wt(input int ctr_w);
    return 1 << (ctr_w - 1);
  endfunction

  // Weakly-not-taken counter value: one below weakly taken.
  function automatic int f_wnt(input int ctr_w);
    return (1 << (ctr_w - 1)) - 1;
  endfunction

  // Saturation ceiling of a ctr_w-bit counter.
  function automatic int f_max(input int ctr_w);
    return (1 << ctr_w) - 1;
  endfunction

  // Ceiling log2, used to size way indices and LRU ages.
  function automatic int f_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // One saturating step up (taken) or down (not taken); counters are at most 4 bits.
  function automatic logic [3:0] f_sat_step(input logic [3:0] ctr, input logic up,
                                            input logic [3:0] max);
    logic [3:0] r;
    r = ctr;
    if (up) begin
      if (ctr < max) r = ctr + 4'd1;
    end else begin
      if (ctr != 4'd0) r = ctr - 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/m_bpred_cam.sv
// rtl/m_bpred_cam.sv - tag match with lowest-index priority encoding
module m_bpred_cam
  import m_bpred_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int ENTRIES = 4,
  parameter int IDX_W   = 2
) (
  input  logic [ENTRIES-1:0][ADDR_W-1:0] tag_i,
  input  logic [ENTRIES-1:0]             valid_i,
  input  logic [ADDR_W-1:0]              addr_i,
  output logic                           hit_o,
  output logic [IDX_W-1:0]               idx_o
);

  // Scan from the top down so the lowest matching way is the last one written.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_i[i] && (tag_i[i] == addr_i)) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/m_bpred_btb.sv
// rtl/m_bpred_btb.sv - fully associative BTB with saturating direction counters and true LRU
module m_bpred_btb #(
  parameter int ADDR_W   = 11,
  parameter int ENTRIES  = 4,
  parameter int CTR_W    = 2,
  parameter int ALLOC_NT = 1
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic [ADDR_W-1:0] w_paddr,
  output logic              w_pre,
  output logic              w_pr,
  output logic [ADDR_W-1:0] w_pdst,
  input  logic              w_be,
  input  logic [ADDR_W-1:0] w_baddr,
  input  logic              w_br,
  input  logic [ADDR_W-1:0] w_bdst,
  input  logic              w_bpr,
  input  logic              w_flush,
  output logic [31:0]       r_upd_cnt,
  output logic [31:0]       r_mis_cnt
);
  import m_bpred_pkg::*;

  localparam int               IDX_W    = f_clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_WT   = CTR_W'(f_wt(CTR_W));
  localparam logic [CTR_W-1:0] CTR_WNT  = CTR_W'(f_wnt(CTR_W));
  localparam logic [3:0]       CTR_MAX4 = 4'(f_max(CTR_W));
  localparam logic [IDX_W-1:0] AGE_OLD  = IDX_W'(ENTRIES - 1);

  logic [ENTRIES-1:0]             valid_q, valid_d;
  logic [ENTRIES-1:0][ADDR_W-1:0] tag_q, tag_d;
  logic [ENTRIES-1:0][ADDR_W-1:0] tgt_q, tgt_d;
  logic [ENTRIES-1:0][CTR_W-1:0]  ctr_q, ctr_d;
  logic [ENTRIES-1:0][IDX_W-1:0]  age_q, age_d;
  logic [31:0]                    upd_cnt_q, upd_cnt_d;
  logic [31:0]                    mis_cnt_q, mis_cnt_d;

  logic             l_hit, u_hit;
  logic [IDX_W-1:0] l_idx, u_idx;
  logic [IDX_W-1:0] vic_idx;
  logic             touch;
  logic [IDX_W-1:0] touch_idx;

  m_bpred_cam #(.ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_cam_lookup (
    .tag_i   (tag_q),
    .valid_i (valid_q),
    .addr_i  (w_paddr),
    .hit_o   (l_hit),
    .idx_o   (l_idx)
  );

  m_bpred_cam #(.ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_cam_update (
    .tag_i   (tag_q),
    .valid_i (valid_q),
    .addr_i  (w_baddr),
    .hit_o   (u_hit),
    .idx_o   (u_idx)
  );

  // Lookup outputs are forced to zero on a miss so stale ways never leak out.
  always_comb begin
    w_pre  = l_hit;
    w_pr   = l_hit & ctr_q[l_idx][CTR_W-1];
    w_pdst = l_hit ? tgt_q[l_idx] : '0;
  end

  assign r_upd_cnt = upd_cnt_q;
  assign r_mis_cnt = mis_cnt_q;

  // Victim: lowest invalid way if any, otherwise the least recently used way.
  always_comb begin
    vic_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (age_q[i] == AGE_OLD) vic_idx = IDX_W'(i);
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) vic_idx = IDX_W'(i);
    end
  end

  // Table next state: flush wins, else hit-update or allocate, then LRU touch.
  always_comb begin
    valid_d   = valid_q;
    tag_d     = tag_q;
    tgt_d     = tgt_q;
    ctr_d     = ctr_q;
    age_d     = age_q;
    touch     = 1'b0;
    touch_idx = '0;
    if (w_flush) begin
      valid_d = '0;
      for (int i = 0; i < ENTRIES; i++) age_d[i] = IDX_W'(i);
    end else if (w_be) begin
      if (u_hit) begin
        ctr_d[u_idx] = CTR_W'(f_sat_step(4'(ctr_q[u_idx]), w_br, CTR_MAX4));
        if (w_br) tgt_d[u_idx] = w_bdst;
        touch     = 1'b1;
        touch_idx = u_idx;
      end else if (w_br || (ALLOC_NT != 0)) begin
        tag_d[vic_idx]   = w_baddr;
        tgt_d[vic_idx]   = w_bdst;
        valid_d[vic_idx] = 1'b1;
        ctr_d[vic_idx]   = w_br ? CTR_WT : CTR_WNT;
        touch            = 1'b1;
        touch_idx        = vic_idx;
      end
      if (touch) begin
        for (int i = 0; i < ENTRIES; i++) begin
          if (age_q[i] < age_q[touch_idx]) age_d[i] = age_q[i] + IDX_W'(1);
        end
        age_d[touch_idx] = '0;
      end
    end
  end

  // Performance counters see every resolved branch, flush or not.
  always_comb begin
    upd_cnt_d = w_be ? upd_cnt_q + 32'd1 : upd_cnt_q;
    mis_cnt_d = (w_be && (w_br != w_bpr)) ? mis_cnt_q + 32'd1 : mis_cnt_q;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      valid_q   <= '0;
      tag_q     <= '0;
      tgt_q     <= '0;
      ctr_q     <= '0;
      for (int i = 0; i < ENTRIES; i++) age_q[i] <= IDX_W'(i);
      upd_cnt_q <= '0;
      mis_cnt_q <= '0;
    end else begin
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      tgt_q     <= tgt_d;
      ctr_q     <= ctr_d;
      age_q     <= age_d;
      upd_cnt_q <= upd_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

endmodule

// File: tb/tb_m_bpred_btb.sv
// tb/tb_m_bpred_btb.sv - directed self-checking bench for m_bpred_btb
module tb_m_bpred_btb;

  logic        clk;
  logic        rst_n;
  logic [10:0] paddr, baddr, bdst, pdst;
  logic        be, br, bpr, flush, pre, pr;
  logic [31:0] upd_cnt, mis_cnt;

  logic [10:0] paddr1, baddr1, bdst1, pdst1;
  logic        be1, br1, bpr1, flush1, pre1, pr1;
  logic [31:0] upd_cnt1, mis_cnt1;

  int errors = 0;
  int checks = 0;

  m_bpred_btb #(.ADDR_W(11), .ENTRIES(4), .CTR_W(2), .ALLOC_NT(0)) dut (
    .w_clk(clk), .w_rst_n(rst_n), .w_paddr(paddr), .w_pre(pre), .w_pr(pr), .w_pdst(pdst),
    .w_be(be), .w_baddr(baddr), .w_br(br), .w_bdst(bdst), .w_bpr(bpr), .w_flush(flush),
    .r_upd_cnt(upd_cnt), .r_mis_cnt(mis_cnt)
  );

  m_bpred_btb #(.ADDR_W(11), .ENTRIES(4), .CTR_W(2), .ALLOC_NT(1)) dut_nt (
    .w_clk(clk), .w_rst_n(rst_n), .w_paddr(paddr1), .w_pre(pre1), .w_pr(pr1), .w_pdst(pdst1),
    .w_be(be1), .w_baddr(baddr1), .w_br(br1), .w_bdst(bdst1), .w_bpr(bpr1), .w_flush(flush1),
    .r_upd_cnt(upd_cnt1), .r_mis_cnt(mis_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic upd(input logic [10:0] a, input logic t, input logic [10:0] d,
                     input logic p, input logic f);
    @(negedge clk);
    be = 1'b1; baddr = a; br = t; bdst = d; bpr = p; flush = f;
    @(negedge clk);
    be = 1'b0; flush = 1'b0;
  endtask

  task automatic upd1(input logic [10:0] a, input logic t, input logic [10:0] d);
    @(negedge clk);
    be1 = 1'b1; baddr1 = a; br1 = t; bdst1 = d; bpr1 = 1'b0;
    @(negedge clk);
    be1 = 1'b0;
  endtask

  task automatic look(input logic [10:0] a);
    paddr = a;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    look(11'h010);
    checks++; if (pre !== 1'b0) begin errors++; $display("FAIL reset_pre got=%0b exp=0", pre); end
    checks++; if (pr !== 1'b0) begin errors++; $display("FAIL reset_pr got=%0b exp=0", pr); end
    checks++; if (pdst !== 11'h000) begin errors++; $display("FAIL reset_pdst got=%h exp=000", pdst); end
    checks++; if (upd_cnt !== 32'd0) begin errors++; $display("FAIL reset_upd got=%0d exp=0", upd_cnt); end
    checks++; if (mis_cnt !== 32'd0) begin errors++; $display("FAIL reset_mis got=%0d exp=0", mis_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_alloc();
    upd(11'h010, 1'b1, 11'h004, 1'b0, 1'b0);
    look(11'h010);
    checks++; if (pre !== 1'b1) begin errors++; $display("FAIL alloc_pre got=%0b exp=1", pre); end
    checks++; if (pr !== 1'b1) begin errors++; $display("FAIL alloc_pr got=%0b exp=1", pr); end
    checks++; if (pdst !== 11'h004) begin errors++; $display("FAIL alloc_pdst got=%h exp=004", pdst); end
    checks++; if (upd_cnt !== 32'd1) begin errors++; $display("FAIL alloc_upd got=%0d exp=1", upd_cnt); end
    checks++; if (mis_cnt !== 32'd1) begin errors++; $display("FAIL alloc_mis got=%0d exp=1", mis_cnt); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) upd(11'h010, 1'b1, 11'h004, 1'b1, 1'b0);
    look(11'h010);
    checks++; if (pr !== 1'b1) begin errors++; $display("FAIL sat_ctr3_pr got=%0b exp=1", pr); end
    upd(11'h010, 1'b0, 11'h3ff, 1'b1, 1'b0);
    look(11'h010);
    checks++; if (pr !== 1'b1) begin errors++; $display("FAIL sat_ctr2_pr got=%0b exp=1", pr); end
    checks++; if (pdst !== 11'h004) begin errors++; $display("FAIL sat_nt_keeps_tgt got=%h exp=004", pdst); end
    upd(11'h010, 1'b0, 11'h3ff, 1'b0, 1'b0);
    upd(11'h010, 1'b0, 11'h3ff, 1'b0, 1'b0);
    look(11'h010);
    checks++; if (pr !== 1'b0) begin errors++; $display("FAIL sat_ctr0_pr got=%0b exp=0", pr); end
    upd(11'h010, 1'b0, 11'h3ff, 1'b0, 1'b0);
    upd(11'h010, 1'b1, 11'h004, 1'b0, 1'b0);
    look(11'h010);
    checks++; if (pr !== 1'b0) begin errors++; $display("FAIL sat_floor_then_inc_pr got=%0b exp=0", pr); end
    upd(11'h010, 1'b1, 11'h055, 1'b0, 1'b0);
    look(11'h010);
    checks++; if (pr !== 1'b1) begin errors++; $display("FAIL sat_ctr2_again_pr got=%0b exp=1", pr); end
    checks++; if (pdst !== 11'h055) begin errors++; $display("FAIL sat_tgt_refresh got=%h exp=055", pdst); end
    checks++; if (upd_cnt !== 32'd10) begin errors++; $display("FAIL sat_upd got=%0d exp=10", upd_cnt); end
    checks++; if (mis_cnt !== 32'd4) begin errors++; $display("FAIL sat_mis got=%0d exp=4", mis_cnt); end
  endtask

  task automatic test_lru();
    logic [10:0] hits [4];
    do_reset();
    for (int i = 0; i < 4; i++) upd(11'h100 + 11'(i), 1'b1, 11'h040 + 11'(i), 1'b1, 1'b0);
    upd(11'h100, 1'b1, 11'h040, 1'b1, 1'b0);
    upd(11'h104, 1'b1, 11'h044, 1'b1, 1'b0);
    look(11'h101);
    checks++; if (pre !== 1'b0) begin errors++; $display("FAIL lru_evict_101 got=%0b exp=0", pre); end
    hits = '{11'h100, 11'h102, 11'h103, 11'h104};
    for (int i = 0; i < 4; i++) begin
      look(hits[i]);
      checks++;
      if (pre !== 1'b1 || pdst !== (hits[i] - 11'h0c0)) begin
        errors++;
        $display("FAIL lru_hit_%h got pre=%0b pdst=%h exp pre=1 pdst=%h", hits[i], pre, pdst,
                 hits[i] - 11'h0c0);
      end
    end
    upd(11'h105, 1'b1, 11'h045, 1'b1, 1'b0);
    look(11'h102);
    checks++; if (pre !== 1'b0) begin errors++; $display("FAIL lru_evict_102 got=%0b exp=0", pre); end
    look(11'h100);
    checks++; if (pre !== 1'b1) begin errors++; $display("FAIL lru_keep_100 got=%0b exp=1", pre); end
  endtask

  task automatic test_nt_miss_and_flush();
    upd(11'h200, 1'b0, 11'h050, 1'b0, 1'b0);
    look(11'h200);
    checks++; if (pre !== 1'b0) begin errors++; $display("FAIL ntmiss_no_alloc got=%0b exp=0", pre); end
    checks++; if (upd_cnt !== 32'd8) begin errors++; $display("FAIL ntmiss_upd got=%0d exp=8", upd_cnt); end
    upd(11'h201, 1'b1, 11'h051, 1'b0, 1'b1);
    look(11'h201);
    checks++; if (pre !== 1'b0) begin errors++; $display("FAIL flush_201 got=%0b exp=0", pre); end
    look(11'h100);
    checks++; if (pre !== 1'b0) begin errors++; $display("FAIL flush_100 got=%0b exp=0", pre); end
    look(11'h104);
    checks++; if (pre !== 1'b0 || pdst !== 11'h000) begin errors++; $display("FAIL flush_104 got pre=%0b pdst=%h exp 0 000", pre, pdst); end
    checks++; if (upd_cnt !== 32'd9) begin errors++; $display("FAIL flush_upd got=%0d exp=9", upd_cnt); end
    checks++; if (mis_cnt !== 32'd1) begin errors++; $display("FAIL flush_mis got=%0d exp=1", mis_cnt); end
    upd(11'h300, 1'b1, 11'h123, 1'b1, 1'b0);
    look(11'h300);
    checks++; if (pre !== 1'b1 || pdst !== 11'h123) begin errors++; $display("FAIL postflush_alloc got pre=%0b pdst=%h exp 1 123", pre, pdst); end
  endtask

  task automatic test_alloc_nt();
    upd1(11'h020, 1'b0, 11'h0aa);
    paddr1 = 11'h020; #1;
    checks++; if (pre1 !== 1'b1 || pr1 !== 1'b0 || pdst1 !== 11'h0aa) begin errors++; $display("FAIL allocnt_wnt got pre=%0b pr=%0b pdst=%h exp 1 0 0aa", pre1, pr1, pdst1); end
    upd1(11'h020, 1'b1, 11'h0bb);
    #1;
    checks++; if (pr1 !== 1'b1 || pdst1 !== 11'h0bb) begin errors++; $display("FAIL allocnt_inc got pr=%0b pdst=%h exp 1 0bb", pr1, pdst1); end
    upd1(11'h020, 1'b0, 11'h0cc);
    #1;
    checks++; if (pr1 !== 1'b0 || pdst1 !== 11'h0bb) begin errors++; $display("FAIL allocnt_dec got pr=%0b pdst=%h exp 0 0bb", pr1, pdst1); end
    checks++; if (upd_cnt1 !== 32'd3 || mis_cnt1 !== 32'd1) begin errors++; $display("FAIL allocnt_cnt got upd=%0d mis=%0d exp 3 1", upd_cnt1, mis_cnt1); end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #2;
    look(11'h300);
    checks++; if (pre !== 1'b1) begin errors++; $display("FAIL areset_pre_before got=%0b exp=1", pre); end
    rst_n = 1'b0;
    #1;
    checks++; if (pre !== 1'b0 || pdst !== 11'h000) begin errors++; $display("FAIL areset_pre got pre=%0b pdst=%h exp 0 000", pre, pdst); end
    checks++; if (upd_cnt !== 32'd0 || mis_cnt !== 32'd0) begin errors++; $display("FAIL areset_cnt got upd=%0d mis=%0d exp 0 0", upd_cnt, mis_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    upd(11'h310, 1'b1, 11'h0f0, 1'b1, 1'b0);
    look(11'h310);
    checks++; if (pre !== 1'b1 || pr !== 1'b1 || pdst !== 11'h0f0) begin errors++; $display("FAIL areset_after got pre=%0b pr=%0b pdst=%h exp 1 1 0f0", pre, pr, pdst); end
    checks++; if (upd_cnt !== 32'd1) begin errors++; $display("FAIL areset_after_upd got=%0d exp=1", upd_cnt); end
  endtask

  initial begin
    paddr = '0; be = 1'b0; baddr = '0; br = 1'b0; bdst = '0; bpr = 1'b0; flush = 1'b0;
    paddr1 = '0; be1 = 1'b0; baddr1 = '0; br1 = 1'b0; bdst1 = '0; bpr1 = 1'b0; flush1 = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_first_alloc();
    test_saturation();
    test_lru();
    test_nt_miss_and_flush();
    test_alloc_nt();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
